// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle main controller for the MIPS datapath.
// Steps each instruction through FETCH/DECODE/EXE/MEM/WB/BRANCH/JUMP and
// drives the datapath strobes and mux selects as a Moore decode of the
// current state and the instruction held in IR (Op/Funct).
module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RFWr,
  output logic       DMWr,
  output logic [1:0] NPCOp,
  output logic [1:0] EXTOp,
  output logic [2:0] ALUOp,
  output logic       BSel,
  output logic [1:0] WDSel,
  output logic [1:0] GPRSel,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned ST_W  = 4;

  // Opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

  // R-type function codes
  localparam logic [OP_W-1:0] FN_ADDU  = 6'b100001;
  localparam logic [OP_W-1:0] FN_SUBU  = 6'b100011;
  localparam logic [OP_W-1:0] FN_SLT   = 6'b101010;
  localparam logic [OP_W-1:0] FN_JR    = 6'b001000;

  // Next-PC modes
  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  // Extender modes
  localparam logic [1:0] EXTOP_ZERO = 2'b00;
  localparam logic [1:0] EXTOP_SIGN = 2'b01;
  localparam logic [1:0] EXTOP_HIGH = 2'b10;

  // ALU operations
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_PASS = 3'b100;

  // Register-file write data / destination selects
  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_DM   = 2'b01;
  localparam logic [1:0] WD_PC4  = 2'b10;
  localparam logic [1:0] GPR_RD  = 2'b00;
  localparam logic [1:0] GPR_RT  = 2'b01;
  localparam logic [1:0] GPR_31  = 2'b10;

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXE    = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WR = 4'd4,
    S_WB_ALU = 4'd5,
    S_WB_MEM = 4'd6,
    S_BRANCH = 4'd7,
    S_JUMP   = 4'd8
  } state_t;

  state_t state_q;
  state_t state_d;

  // Instruction decode of the IR fields
  logic is_r, r_addu, r_subu, r_slt, r_jr, r_alu;
  logic i_ori, i_lui, i_addiu, i_lw, i_sw, i_beq, j_j, j_jal;
  logic is_itype, go_exe, go_jump;
  logic [1:0] ext_dec;
  logic [2:0] alu_dec;

  // Classify the current instruction
  always_comb begin
    is_r     = (Op == OP_RTYPE);
    r_addu   = is_r && (Funct == FN_ADDU);
    r_subu   = is_r && (Funct == FN_SUBU);
    r_slt    = is_r && (Funct == FN_SLT);
    r_jr     = is_r && (Funct == FN_JR);
    r_alu    = r_addu || r_subu || r_slt;
    i_ori    = (Op == OP_ORI);
    i_lui    = (Op == OP_LUI);
    i_addiu  = (Op == OP_ADDIU);
    i_lw     = (Op == OP_LW);
    i_sw     = (Op == OP_SW);
    i_beq    = (Op == OP_BEQ);
    j_j      = (Op == OP_J);
    j_jal    = (Op == OP_JAL);
    is_itype = i_ori || i_lui || i_addiu || i_lw || i_sw;
    go_exe   = r_alu || is_itype;
    go_jump  = j_j || j_jal || r_jr;
  end

  // Extender mode and EXE-stage ALU operation per instruction
  always_comb begin
    ext_dec = EXTOP_ZERO;
    if (i_lui) begin
      ext_dec = EXTOP_HIGH;
    end else if (i_addiu || i_lw || i_sw || i_beq) begin
      ext_dec = EXTOP_SIGN;
    end

    alu_dec = ALU_ADD;
    if (r_subu) begin
      alu_dec = ALU_SUB;
    end else if (r_slt) begin
      alu_dec = ALU_SLT;
    end else if (i_ori) begin
      alu_dec = ALU_OR;
    end else if (i_lui) begin
      alu_dec = ALU_PASS;
    end
  end

  // State register; reset returns to FETCH immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode; outputs held low throughout reset
  always_comb begin
    state_d = state_q;
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    RFWr    = 1'b0;
    DMWr    = 1'b0;
    NPCOp   = NPC_PC4;
    EXTOp   = EXTOP_ZERO;
    ALUOp   = ALU_ADD;
    BSel    = 1'b0;
    WDSel   = WD_ALU;
    GPRSel  = GPR_RD;
    Illegal = 1'b0;

    if (state_q != S_FETCH) begin
      EXTOp = ext_dec;
    end

    case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
        PCWr    = 1'b1;
        IRWr    = 1'b1;
        NPCOp   = NPC_PC4;
      end
      S_DECODE: begin
        if (i_beq) begin
          state_d = S_BRANCH;
        end else if (go_jump) begin
          state_d = S_JUMP;
        end else if (go_exe) begin
          state_d = S_EXE;
        end else begin
          state_d = S_FETCH;
          Illegal = 1'b1;
        end
      end
      S_EXE: begin
        ALUOp = alu_dec;
        BSel  = is_itype;
        if (i_lw) begin
          state_d = S_MEM_RD;
        end else if (i_sw) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_WB_ALU;
        end
      end
      S_MEM_RD: begin
        state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        state_d = S_FETCH;
        DMWr    = 1'b1;
      end
      S_WB_ALU: begin
        state_d = S_FETCH;
        RFWr    = 1'b1;
        WDSel   = WD_ALU;
        GPRSel  = is_r ? GPR_RD : GPR_RT;
      end
      S_WB_MEM: begin
        state_d = S_FETCH;
        RFWr    = 1'b1;
        WDSel   = WD_DM;
        GPRSel  = GPR_RT;
      end
      S_BRANCH: begin
        state_d = S_FETCH;
        ALUOp   = ALU_SUB;
        BSel    = 1'b0;
        PCWr    = Zero;
        NPCOp   = NPC_BRANCH;
      end
      S_JUMP: begin
        state_d = S_FETCH;
        PCWr    = 1'b1;
        if (r_jr) begin
          NPCOp = NPC_JR;
        end else begin
          NPCOp = NPC_JUMP;
        end
        if (j_jal) begin
          RFWr   = 1'b1;
          WDSel  = WD_PC4;
          GPRSel = GPR_31;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Strobes must not leak while the controller is held in reset
    if (!rst) begin
      PCWr    = 1'b0;
      IRWr    = 1'b0;
      RFWr    = 1'b0;
      DMWr    = 1'b0;
      NPCOp   = NPC_PC4;
      EXTOp   = EXTOP_ZERO;
      ALUOp   = ALU_ADD;
      BSel    = 1'b0;
      WDSel   = WD_ALU;
      GPRSel  = GPR_RD;
      Illegal = 1'b0;
    end
  end

  assign State = ST_W'(state_q);

endmodule
